i2s_tx: RTL

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/audio_pkg.sv | 14 +
 rtl/i2s_clkgen.sv | 40 ++++
 rtl/i2s_tx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S transmit path.
package audio_pkg;

  localparam int SAMPLE_BITS    = 16;
  localparam int MCLK_PER_FRAME = 256;
  localparam int BCLK_DIV       = 4;
  localparam int SLOT_BITS      = 32;

  // Width of the mclk-per-frame counter (8 bits for 256 mclk).
  localparam int CNT_BITS = $clog2(MCLK_PER_FRAME);

  typedef logic signed [SAMPLE_BITS-1:0] sample_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Frame timing: free-running mclk counter, registered bclk/lrclk and the
// end-of-frame load strobe.
module i2s_clkgen
  import audio_pkg::*;
(
  input  logic                mclk,
  input  logic                rst,
  output logic [CNT_BITS-1:0] c,
  output logic                bclk,
  output logic                lrclk,
  output logic                load
);

  localparam int                 DIV_BITS = $clog2(BCLK_DIV);
  localparam logic [CNT_BITS-1:0] LAST_C  = CNT_BITS'(MCLK_PER_FRAME - 1);

  // Frame counter: one step per mclk, wraps naturally at the end of a frame.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      c <= '0;
    end else begin
      c <= c + CNT_BITS'(1);
    end
  end

  // Bit clock and word select, registered so they trail c by one mclk.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      bclk  <= 1'b0;
      lrclk <= 1'b0;
    end else begin
      bclk  <= c[DIV_BITS-1];
      lrclk <= c[CNT_BITS-1];
    end
  end

  // Last mclk of the frame is when the next frame's samples are loaded.
  assign load = (c == LAST_C);

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: captures stereo samples, loads them once per frame and
// serialises them MSB-first, one bclk after the word-select change.
//
// Handshake: valid is a one-mclk qualifier for sample_l/sample_r with no
// ready; the block never backpressures and accepts every valid sample into
// its hold registers (latest wins). sample_req marks the load cycle so a
// source can align its next sample to the frame.
module i2s_tx #(
  parameter int SAMPLE_BITS   = audio_pkg::SAMPLE_BITS,
  parameter int UNDERRUN_BITS = 8
) (
  input  logic                     mclk,
  input  logic                     rst,
  input  logic [SAMPLE_BITS-1:0]   sample_l,
  input  logic [SAMPLE_BITS-1:0]   sample_r,
  input  logic                     valid,
  input  logic                     mute,
  output logic                     bclk,
  output logic                     lrclk,
  output logic                     sdata,
  output logic                     sample_req,
  output logic [UNDERRUN_BITS-1:0] underrun_cnt
);

  import audio_pkg::*;

  localparam int DIV_BITS  = $clog2(BCLK_DIV);
  localparam int SLOT_IDX  = $clog2(SLOT_BITS);
  localparam logic [SLOT_IDX-1:0]      LAST_DATA_SLOT = SLOT_IDX'(SAMPLE_BITS);
  localparam logic [UNDERRUN_BITS-1:0] UNDERRUN_MAX   = '1;

  logic [CNT_BITS-1:0]    c;
  logic                   load;
  logic [SLOT_IDX-1:0]    slot;
  logic [DIV_BITS-1:0]    phase;
  logic                   right;
  logic                   data_slot;
  logic                   shift_now;
  logic                   starved;
  logic                   fresh;
  logic                   sdata_next;
  logic [SAMPLE_BITS-1:0] hold_l, hold_r;
  logic [SAMPLE_BITS-1:0] shift_l, shift_r;
  logic [SAMPLE_BITS-1:0] next_l, next_r;

  i2s_clkgen u_clkgen (
    .mclk  (mclk),
    .rst   (rst),
    .c     (c),
    .bclk  (bclk),
    .lrclk (lrclk),
    .load  (load)
  );

  assign sample_req = load;

  // Slot decode: slot 0 is the I2S one-bit delay, slots 1..SAMPLE_BITS carry data.
  assign phase     = c[DIV_BITS-1:0];
  assign slot      = c[DIV_BITS +: SLOT_IDX];
  assign right     = c[CNT_BITS-1];
  assign data_slot = (slot != '0) && (slot <= LAST_DATA_SLOT);
  assign shift_now = data_slot && (phase == '1);

  // A load is starved when nothing arrived since the last load, counting this cycle.
  assign starved = !(fresh || valid);

  // Load values: mute forces silence, a same-cycle sample bypasses the hold.
  always_comb begin
    next_l = hold_l;
    next_r = hold_r;
    if (mute) begin
      next_l = '0;
      next_r = '0;
    end else if (valid) begin
      next_l = sample_l;
      next_r = sample_r;
    end
  end

  // Hold registers: keep the most recent valid sample pair.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      hold_l <= '0;
      hold_r <= '0;
    end else if (valid) begin
      hold_l <= sample_l;
      hold_r <= sample_r;
    end
  end

  // Fresh flag: a sample has arrived since the last frame load.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      fresh <= 1'b0;
    end else if (load) begin
      fresh <= 1'b0;
    end else if (valid) begin
      fresh <= 1'b1;
    end
  end

  // Underrun counter: saturating count of starved loads.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      underrun_cnt <= '0;
    end else if (load && starved && (underrun_cnt != UNDERRUN_MAX)) begin
      underrun_cnt <= underrun_cnt + UNDERRUN_BITS'(1);
    end
  end

  // Shift registers: parallel load at the frame boundary, then shift one bit
  // per data slot of the active channel on the last mclk of the slot.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      shift_l <= '0;
      shift_r <= '0;
    end else if (load) begin
      shift_l <= next_l;
      shift_r <= next_r;
    end else if (shift_now) begin
      if (right) begin
        shift_r <= shift_r << 1;
      end else begin
        shift_l <= shift_l << 1;
      end
    end
  end

  assign sdata_next = data_slot && (right ? shift_r[SAMPLE_BITS-1] : shift_l[SAMPLE_BITS-1]);

  // Serial data register, trailing c by one mclk like bclk and lrclk.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      sdata <= 1'b0;
    end else begin
      sdata <= sdata_next;
    end
  end

endmodule
